fetch_unit: RTL

- Instruction-fetch stage. Owns the fetch PC, issues requests to instruction memory over a request/grant + response-valid handshake, and holds one fetched instruction slot.
- Slot outputs inst/pc/pc4 drive the IF/ID pipeline register directly.
- Honours the hazard unit's fetch stall and the execute-stage branch/jump redirect, including discarding in-flight responses on the wrong path.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_slot.sv | 48 ++++
 rtl/fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and fetch-state encoding for the fetch stage.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE: nothing in flight; WAIT: response owed; WAIT_KILL: owed response is stale
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_KILL = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_slot.sv
`default_nettype none
// ============================================================================
// Module   : fetch_slot
// Brief    : Single fetched-instruction slot feeding IF/ID; NOP when empty.
// Revision : 1.0
// ============================================================================
module fetch_slot #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            flush,
    input  logic            fill,
    input  logic            consume,
    input  logic [XLEN-1:0] fill_inst,
    input  logic [XLEN-1:0] fill_pc,
    output logic            slot_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);
    import riscv_pkg::*;

    logic [XLEN-1:0] inst_q;

    // A fill on the consume edge replaces the departing entry, so fill wins.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            slot_valid <= 1'b0;
            inst_q     <= '0;
            pc         <= '0;
            pc4        <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (fill) begin
            slot_valid <= 1'b1;
            inst_q     <= fill_inst;
            pc         <= fill_pc;
            pc4        <= fill_pc + XLEN'(4);
        end else if (slot_valid && consume) begin
            slot_valid <= 1'b0;
        end
    end

    assign inst = slot_valid ? inst_q : XLEN'(NOP_INSTR);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch PC, single-outstanding imem handshake, redirect/kill control.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic            fetch_valid
);
    import riscv_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            kill;
    logic            grant;
    logic            resp;
    logic            fill;
    logic            slot_valid;

    assign outstanding = (state != IDLE);
    assign kill        = (state == WAIT_KILL);

    assign imem_req  = ~Rst & ~PCSrcE & ~outstanding & (~slot_valid | ~StallF);
    assign imem_addr = pcf;
    assign grant     = imem_req & imem_gnt;
    assign resp      = outstanding & imem_rvalid;
    // A response landing with a redirect is already on the wrong path.
    assign fill      = resp & ~kill & ~PCSrcE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (grant) state_next = WAIT;
            WAIT: begin
                if (resp)        state_next = IDLE;
                else if (PCSrcE) state_next = WAIT_KILL;
            end
            WAIT_KILL: if (resp) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            pcf    <= RESET_PC;
            req_pc <= '0;
        end else begin
            state <= state_next;
            if (PCSrcE) begin
                pcf <= {PCTargetE[XLEN-1:2], 2'b00};
            end else if (grant) begin
                pcf <= pcf + XLEN'(4);
            end
            if (grant) begin
                req_pc <= pcf;
            end
        end
    end

    fetch_slot #(
        .XLEN (XLEN)
    ) u_slot (
        .Clk        (Clk),
        .Rst        (Rst),
        .flush      (PCSrcE),
        .fill       (fill),
        .consume    (~StallF),
        .fill_inst  (imem_rdata),
        .fill_pc    (req_pc),
        .slot_valid (slot_valid),
        .inst       (inst),
        .pc         (pc),
        .pc4        (pc4)
    );

    assign fetch_valid = slot_valid;

endmodule
`default_nettype wire
